// File: rtl/snn_pkg.sv
// Shared types, defaults and arithmetic helpers for the spiking-network blocks.
package snn_pkg;

    // Default datapath width and firing threshold, shared with synapse parameters.
    localparam int WIDTH_DEFAULT  = 32;
    localparam int THRESH_DEFAULT = 32;

    // Widest datapath the saturating helper supports.
    localparam int SAT_MAXW = 64;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_COL = 2'd1,
        INTEG    = 2'd2,
        FIRE     = 2'd3
    } lif_state_t;

    typedef logic signed [SAT_MAXW:0] sat_wide_t;

    // Clamp a sign-extended WIDTH+1-bit sum into the range of a w-bit signed
    // value; the caller narrows the result back to w bits.
    function automatic sat_wide_t sat_add(input sat_wide_t sum, input int unsigned w);
        sat_wide_t hi;
        sat_wide_t lo;
        hi = (sat_wide_t'(1'b1) <<< (w - 32'd1)) - sat_wide_t'(1'b1);
        lo = -(sat_wide_t'(1'b1) <<< (w - 32'd1));
        if (sum > hi) begin
            sat_add = hi;
        end else if (sum < lo) begin
            sat_add = lo;
        end else begin
            sat_add = sum;
        end
    endfunction

endpackage

// File: rtl/spike_delay_line.sv
// Programmable spike delay line: one new spike bit per shift, tap selects
// how many shifts ago the bit entered (0 = the bit entering right now).
module spike_delay_line #(
    parameter int MAX_DELAY = 8,
    parameter int DW        = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          shift_en,
    input  logic          din,
    input  logic [DW-1:0] sel,
    output logic          tap
);

    generate
        if (MAX_DELAY > 1) begin : g_line
            localparam logic [DW-1:0] LAST_SEL = DW'(MAX_DELAY - 1);

            // Only MAX_DELAY-1 history bits are stored; the incoming bit is tap 0.
            logic [MAX_DELAY-2:0] hist_r;
            logic [MAX_DELAY-1:0] taps_s;
            logic [MAX_DELAY-1:0] onehot_s;
            logic [DW-1:0]        sel_sat_s;

            // Clamp out-of-range selects to the deepest tap.
            always_comb begin
                sel_sat_s = sel;
                if (sel > LAST_SEL) begin
                    sel_sat_s = LAST_SEL;
                end else begin
                    sel_sat_s = sel;
                end
            end

            assign taps_s   = {hist_r, din};
            assign onehot_s = MAX_DELAY'(1'b1) << sel_sat_s;
            assign tap      = |(taps_s & onehot_s);

            // Shift history by one position on each enabled step.
            always_ff @(posedge clk) begin
                if (rst) begin
                    hist_r <= {(MAX_DELAY-1){1'b0}};
                end else if (shift_en) begin
                    hist_r <= taps_s[MAX_DELAY-2:0];
                end
            end
        end else begin : g_wire
            assign tap = din;
        end
    endgenerate

endmodule

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron fed by one crossbar column; emits a
// (optionally delayed) spike and a done pulse once per timestep.
module lif_neuron
    import snn_pkg::*;
#(
    parameter int                      WIDTH      = WIDTH_DEFAULT,
    parameter logic signed [WIDTH-1:0] THRESH     = WIDTH'(THRESH_DEFAULT),
    parameter int                      LEAK_SHIFT = 3,
    parameter int                      REFRACT    = 2,
    parameter int                      MAX_DELAY  = 8,
    parameter int                      DW         = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tick,
    input  logic                    col_done,
    input  logic signed [WIDTH-1:0] mac_in,
    input  logic [DW-1:0]           delay,
    output logic                    spk_out,
    output logic signed [WIDTH-1:0] v_mem,
    output logic                    done,
    output logic                    busy,
    output logic                    overrun
);

    localparam int RW = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;

    lif_state_t              state_r;
    lif_state_t              state_next_s;
    logic signed [WIDTH-1:0] v_r;
    logic signed [WIDTH-1:0] mac_r;
    logic signed [WIDTH-1:0] v_next_s;
    logic [RW-1:0]           refr_r;
    logic signed [WIDTH:0]   v_ext_s;
    logic signed [WIDTH:0]   leak_ext_s;
    logic signed [WIDTH:0]   mac_ext_s;
    logic signed [WIDTH:0]   sum_s;
    logic                    refr_active_s;
    logic                    fire_now_s;
    logic                    shift_en_s;
    logic                    tap_s;
    logic                    spk_r;
    logic                    done_r;
    logic                    busy_r;
    logic                    overrun_r;

    // Leak, integrate and saturate; the sum cannot overflow WIDTH+1 bits.
    always_comb begin
        v_ext_s   = {v_r[WIDTH-1], v_r};
        mac_ext_s = {mac_r[WIDTH-1], mac_r};
        if (LEAK_SHIFT == 0) begin
            leak_ext_s = {(WIDTH+1){1'b0}};
        end else begin
            leak_ext_s = v_ext_s >>> LEAK_SHIFT;
        end
        sum_s         = v_ext_s - leak_ext_s + mac_ext_s;
        v_next_s      = WIDTH'(sat_add(sat_wide_t'(sum_s), WIDTH));
        refr_active_s = (refr_r != {RW{1'b0}});
        if (refr_active_s) begin
            fire_now_s = 1'b0;
        end else begin
            fire_now_s = (v_next_s >= THRESH);
        end
    end

    // Next-state logic of the timestep sequencer.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (tick) begin
                    state_next_s = WAIT_COL;
                end else begin
                    state_next_s = IDLE;
                end
            end
            WAIT_COL: begin
                if (col_done) begin
                    state_next_s = INTEG;
                end else begin
                    state_next_s = WAIT_COL;
                end
            end
            INTEG:   state_next_s = FIRE;
            FIRE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Membrane, refractory counter and output pulses; results of the INTEG
    // cycle are registered so done/spk_out are visible during FIRE.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_r       <= {WIDTH{1'b0}};
            mac_r     <= {WIDTH{1'b0}};
            refr_r    <= {RW{1'b0}};
            spk_r     <= 1'b0;
            done_r    <= 1'b0;
            busy_r    <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            spk_r  <= 1'b0;
            done_r <= 1'b0;
            busy_r <= (state_next_s != IDLE);
            if (tick && (state_r != IDLE)) begin
                overrun_r <= 1'b1;
            end
            if ((state_r == WAIT_COL) && col_done) begin
                mac_r <= mac_in;
            end
            if (state_r == INTEG) begin
                done_r <= 1'b1;
                spk_r  <= tap_s;
                if (refr_active_s) begin
                    refr_r <= refr_r - RW'(1);
                end else if (fire_now_s) begin
                    v_r    <= {WIDTH{1'b0}};
                    refr_r <= RW'(REFRACT);
                end else begin
                    v_r <= v_next_s;
                end
            end
        end
    end

    assign shift_en_s = (state_r == INTEG);

    spike_delay_line #(
        .MAX_DELAY (MAX_DELAY),
        .DW        (DW)
    ) u_delay (
        .clk      (clk),
        .rst      (rst),
        .shift_en (shift_en_s),
        .din      (fire_now_s),
        .sel      (delay),
        .tap      (tap_s)
    );

    assign spk_out = spk_r;
    assign v_mem   = v_r;
    assign done    = done_r;
    assign busy    = busy_r;
    assign overrun = overrun_r;

endmodule

// File: tb/tb_lif_neuron.sv
// Directed testbench for lif_neuron: a default-leak instance (with a 4-bit
// delay select so out-of-range delays can be driven) and a no-leak instance
// with a high threshold for saturation cases.
module tb_lif_neuron;

    logic        clk;
    logic        rst;
    logic        tick;
    logic        col_done;
    logic [31:0] mac_in;
    logic [3:0]  delay;
    logic        spk_out;
    logic [31:0] v_mem;
    logic        done;
    logic        busy;
    logic        overrun;

    logic        tick2;
    logic        col_done2;
    logic [31:0] mac2;
    logic [2:0]  delay2;
    logic        spk2;
    logic [31:0] v2;
    logic        done2;
    logic        busy2;
    logic        ovr2;

    int checks = 0;
    int errors = 0;

    lif_neuron #(.DW(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .col_done (col_done),
        .mac_in   (mac_in),
        .delay    (delay),
        .spk_out  (spk_out),
        .v_mem    (v_mem),
        .done     (done),
        .busy     (busy),
        .overrun  (overrun)
    );

    lif_neuron #(.LEAK_SHIFT(0), .THRESH(32'h7FFF_FFFF)) dut2 (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick2),
        .col_done (col_done2),
        .mac_in   (mac2),
        .delay    (delay2),
        .spk_out  (spk2),
        .v_mem    (v2),
        .done     (done2),
        .busy     (busy2),
        .overrun  (ovr2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One timestep: tick, optional wait, col_done with m; returns what was seen
    // in the done cycle, latency from col_done, and done one cycle later.
    task automatic run_step(input int which, input logic [31:0] m, input logic [3:0] d,
                            input int gap, output logic spk, output logic [31:0] v,
                            output int lat, output logic done_next);
        @(posedge clk); #1;
        if (which == 1) begin tick = 1'b1; delay = d; end
        else begin tick2 = 1'b1; delay2 = d[2:0]; end
        @(posedge clk); #1;
        tick = 1'b0; tick2 = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        if (which == 1) begin col_done = 1'b1; mac_in = m; end
        else begin col_done2 = 1'b1; mac2 = m; end
        @(posedge clk); #1;
        col_done = 1'b0; col_done2 = 1'b0;
        lat = -1; spk = 1'b0; v = 32'd0; done_next = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (lat < 0) begin
                if (((which == 1) ? done : done2) === 1'b1) begin
                    lat = k;
                    spk = (which == 1) ? spk_out : spk2;
                    v   = (which == 1) ? v_mem : v2;
                end else begin
                    @(posedge clk); #1;
                end
            end
        end
        if (lat >= 0) begin
            @(posedge clk); #1;
            done_next = (which == 1) ? done : done2;
        end
    endtask

    task automatic test_reset();
        logic seen_done;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checks++; if (v_mem !== 32'd0) begin errors++; $display("FAIL reset_v_mem: got %h expected %h", v_mem, 32'd0); end
        checks++; if (spk_out !== 1'b0) begin errors++; $display("FAIL reset_spk: got %b expected 0", spk_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        // tick together with col_done: only the tick is taken
        @(posedge clk); #1;
        tick = 1'b1; col_done = 1'b1; mac_in = 32'd5;
        @(posedge clk); #1;
        tick = 1'b0; col_done = 1'b0;
        seen_done = 1'b0;
        repeat (5) begin
            if (done === 1'b1) seen_done = 1'b1;
            @(posedge clk); #1;
        end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wait_busy: got %b expected 1", busy); end
        checks++; if (seen_done !== 1'b0) begin errors++; $display("FAIL wait_no_done: got %b expected 0", seen_done); end
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rerst_busy: got %b expected 0", busy); end
    endtask

    task automatic test_subthreshold();
        logic        spk;
        logic [31:0] v;
        int          lat;
        logic        dn;
        logic [31:0] exp_v [3];
        exp_v = '{32'd10, 32'd19, 32'd27};
        for (int i = 0; i < 3; i++) begin
            run_step(1, 32'd10, 4'd0, (i == 1) ? 2 : 0, spk, v, lat, dn);
            checks++; if (v !== exp_v[i]) begin errors++; $display("FAIL subthr_v[%0d]: got %0d expected %0d", i, v, exp_v[i]); end
            checks++; if (spk !== 1'b0) begin errors++; $display("FAIL subthr_spk[%0d]: got %b expected 0", i, spk); end
            checks++; if (lat !== 2) begin errors++; $display("FAIL subthr_latency[%0d]: got %0d expected 2", i, lat); end
            checks++; if (dn !== 1'b0) begin errors++; $display("FAIL subthr_done_pulse[%0d]: got %b expected 0", i, dn); end
        end
    endtask

    task automatic test_fire_refractory();
        logic        spk;
        logic [31:0] v;
        int          lat;
        logic        dn;
        logic [31:0] mac_t [4];
        logic        exp_spk [4];
        mac_t   = '{32'd10, 32'd100, 32'd100, 32'd100};
        exp_spk = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            run_step(1, mac_t[i], 4'd0, 0, spk, v, lat, dn);
            checks++; if (spk !== exp_spk[i]) begin errors++; $display("FAIL fire_spk[%0d]: got %b expected %b", i, spk, exp_spk[i]); end
            checks++; if (v !== 32'd0) begin errors++; $display("FAIL fire_v[%0d]: got %0d expected 0", i, v); end
            checks++; if (lat !== 2) begin errors++; $display("FAIL fire_latency[%0d]: got %0d expected 2", i, lat); end
        end
    endtask

    task automatic test_delay();
        logic        spk;
        logic [31:0] v;
        int          lat;
        logic        dn;
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            run_step(1, (k == 0) ? 32'd40 : 32'd0, 4'd3, 0, spk, v, lat, dn);
            checks++; if (spk !== (k == 3)) begin errors++; $display("FAIL delay3_spk[step %0d]: got %b expected %b", k, spk, (k == 3)); end
        end
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        for (int k = 0; k < 9; k++) begin
            run_step(1, (k == 0) ? 32'd40 : 32'd0, 4'd9, 0, spk, v, lat, dn);
            checks++; if (spk !== (k == 7)) begin errors++; $display("FAIL delay9_spk[step %0d]: got %b expected %b", k, spk, (k == 7)); end
        end
        checks++; if (lat !== 2) begin errors++; $display("FAIL delay_latency: got %0d expected 2", lat); end
    endtask

    task automatic test_saturation();
        logic        spk;
        logic [31:0] v;
        int          lat;
        logic        dn;
        logic [31:0] mac_t [7];
        logic [31:0] exp_v [7];
        logic        exp_spk [7];
        mac_t   = '{32'h7FFF_FFF0, 32'h7FFF_FFFF, 32'h0, 32'h0, 32'hFFFF_FFF0, 32'h8000_0000, 32'hFFFF_FFFF};
        exp_v   = '{32'h7FFF_FFF0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFF0, 32'h8000_0000, 32'h8000_0000};
        exp_spk = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 7; i++) begin
            run_step(2, mac_t[i], 4'd0, 0, spk, v, lat, dn);
            checks++; if (v !== exp_v[i]) begin errors++; $display("FAIL sat_v[%0d]: got %h expected %h", i, v, exp_v[i]); end
            checks++; if (spk !== exp_spk[i]) begin errors++; $display("FAIL sat_spk[%0d]: got %b expected %b", i, spk, exp_spk[i]); end
        end
    endtask

    task automatic test_overrun_reset();
        @(posedge clk); #1 tick = 1'b1;
        @(posedge clk); #1 tick = 1'b0;
        @(posedge clk); #1 tick = 1'b1;
        @(posedge clk); #1 tick = 1'b0;
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b expected 1", overrun); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL overrun_busy: got %b expected 1", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL overrun_no_done: got %b expected 0", done); end
        repeat (2) begin @(posedge clk); #1; end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky: got %b expected 1", overrun); end
        col_done = 1'b1; mac_in = 32'd40;
        @(posedge clk); #1;
        col_done = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        checks++; if (v_mem !== 32'd0) begin errors++; $display("FAIL midrst_v_mem: got %h expected 0", v_mem); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b expected 0", done); end
        checks++; if (spk_out !== 1'b0) begin errors++; $display("FAIL midrst_spk: got %b expected 0", spk_out); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL midrst_overrun: got %b expected 0", overrun); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done_late: got %b expected 0", done); end
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; col_done = 1'b0; mac_in = 32'd0; delay = 4'd0;
        tick2 = 1'b0; col_done2 = 1'b0; mac2 = 32'd0; delay2 = 3'd0;
        test_reset();
        test_subthreshold();
        test_fire_refractory();
        test_delay();
        test_saturation();
        test_overrun_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
